// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: standard payload layouts, occupancy encodings, bubble value.
package pipe_pkg;

    // EX/MEM payload, LSB first: extimm, instr, PC, memToReg, dmWE, grfWriteAddr, dmWriteData, aluOut
    localparam int EXME_W          = 168;
    localparam int EXME_EXTIMM_OFF = 0;
    localparam int EXME_INSTR_OFF  = 32;
    localparam int EXME_PC_OFF     = 64;
    localparam int EXME_M2R_OFF    = 96;
    localparam int EXME_M2R_W      = 2;
    localparam int EXME_DMWE_OFF   = 98;
    localparam int EXME_GRFWA_OFF  = 99;
    localparam int EXME_GRFWA_W    = 5;
    localparam int EXME_DMWD_OFF   = 104;
    localparam int EXME_ALU_OFF    = 136;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Bubble: instr = 0 (nop) and every write-enable low.
    localparam logic [EXME_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data bundle between two pipeline stages.
interface pipe_stage_skid_if #(
    parameter int W = 168
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_slot.sv
// One valid+data holding register; clear wins over load and restores the bubble.
module pipe_reg_slot
    import pipe_pkg::*;
#(
    parameter int W = EXME_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = W'(BUBBLE);
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= W'(BUBBLE);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid and flush-to-bubble.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = EXME_W,
    parameter bit SKID      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  dn,
    input  logic               flush,
    output logic [1:0]         occupancy
);

    occ_e                 state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 in_ready, accept, pop;
    logic                 main_vld, skid_vld;
    logic [PAYLOAD_W-1:0] main_data, skid_data, main_din;
    logic                 main_load, main_clr, skid_load, skid_clr;

    // With the skid, in_ready is a flop so out_ready never reaches upstream combinationally.
    always_comb begin
        if (SKID) in_ready = in_ready_q;
        else      in_ready = !main_vld || dn.ready;
    end

    assign accept = up.valid && in_ready;
    assign pop    = main_vld && dn.ready;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_din  = up.data;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = OCC_TWO;
                end else if (pop) begin
                    main_clr  = 1'b1;
                    state_d   = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // Skid drains into main; the skid entry is never bypassed.
                if (pop) begin
                    main_load = 1'b1;
                    main_din  = skid_data;
                    skid_clr  = 1'b1;
                    state_d   = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
            state_d   = OCC_EMPTY;
        end
        in_ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_reg_slot #(.W(PAYLOAD_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_din),
        .valid (main_vld),
        .data  (main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_reg_slot #(.W(PAYLOAD_W)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .clear (skid_clr),
                .d     (up.data),
                .valid (skid_vld),
                .data  (skid_data)
            );
        end else begin : g_noskid
            assign skid_vld  = 1'b0;
            assign skid_data = '0;
        end
    endgenerate

    assign up.ready  = in_ready;
    assign dn.valid  = main_vld;
    assign dn.data   = main_data;
    assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks of pipe_stage_skid in SKID=1 and SKID=0 builds.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int PW = EXME_W;
    typedef logic [PW-1:0] pw_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush1, flush0;
    logic [1:0] occ1, occ0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.W(PW)) up1 ();
    pipe_stage_skid_if #(.W(PW)) dn1 ();
    pipe_stage_skid_if #(.W(PW)) up0 ();
    pipe_stage_skid_if #(.W(PW)) dn0 ();

    pipe_stage_skid #(.PAYLOAD_W(PW), .SKID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .up(up1), .dn(dn1), .flush(flush1), .occupancy(occ1)
    );
    pipe_stage_skid #(.PAYLOAD_W(PW), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .up(up0), .dn(dn0), .flush(flush0), .occupancy(occ0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input pw_t obs, input pw_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        up1.valid = 1'b0; up1.data = '0; dn1.ready = 1'b0; flush1 = 1'b0;
        up0.valid = 1'b0; up0.data = '0; dn0.ready = 1'b0; flush0 = 1'b0;
    endtask

    pw_t q1[$], q0[$];
    logic acc1, acc0, pop1, pop0, er1, er0;

    initial begin
        idle();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_vld",  pw_t'(dn1.valid), pw_t'(0));
        chk("rst_data", dn1.data,         pw_t'(0));
        chk("rst_occ",  pw_t'(occ1),      pw_t'(0));
        chk("rst_rdy",  pw_t'(up1.ready), pw_t'(1));

        // Stream 1,2,3 with out_ready high
        dn1.ready = 1'b1;
        up1.valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            up1.data = pw_t'(i);
            cyc();
            chk("str_data", dn1.data,         pw_t'(i));
            chk("str_occ",  pw_t'(occ1),      pw_t'(1));
            chk("str_rdy",  pw_t'(up1.ready), pw_t'(1));
        end
        up1.valid = 1'b0;
        cyc();
        chk("str_drain", pw_t'(occ1), pw_t'(0));

        // Stall fill: A, B into skid, C held upstream
        dn1.ready = 1'b0;
        up1.valid = 1'b1; up1.data = pw_t'('hA);
        cyc();
        chk("fill_occ1", pw_t'(occ1),      pw_t'(1));
        chk("fill_rdy1", pw_t'(up1.ready), pw_t'(1));
        up1.data = pw_t'('hB);
        cyc();
        chk("fill_occ2", pw_t'(occ1),      pw_t'(2));
        chk("fill_rdy2", pw_t'(up1.ready), pw_t'(0));
        up1.data = pw_t'('hC);
        cyc();
        chk("fill_hold", dn1.data,    pw_t'('hA));
        chk("fill_hocc", pw_t'(occ1), pw_t'(2));
        dn1.ready = 1'b1;
        cyc();
        chk("drain_b",  dn1.data,    pw_t'('hB));
        chk("drain_bo", pw_t'(occ1), pw_t'(1));
        cyc();
        chk("drain_c",  dn1.data,    pw_t'('hC));
        up1.valid = 1'b0;
        cyc();
        chk("drain_e",  pw_t'(dn1.valid), pw_t'(0));

        // Flush with a full skid; same-cycle 0xD must be dropped
        dn1.ready = 1'b0;
        up1.valid = 1'b1; up1.data = pw_t'('h1A);
        cyc();
        up1.data = pw_t'('h1B);
        cyc();
        chk("fl_pre", pw_t'(occ1), pw_t'(2));
        flush1 = 1'b1; up1.data = pw_t'('hD);
        cyc();
        flush1 = 1'b0; up1.valid = 1'b0; dn1.ready = 1'b1;
        chk("fl_vld",  pw_t'(dn1.valid), pw_t'(0));
        chk("fl_data", dn1.data,         pw_t'(0));
        chk("fl_occ",  pw_t'(occ1),      pw_t'(0));
        chk("fl_rdy",  pw_t'(up1.ready), pw_t'(1));
        cyc();
        chk("fl_nod",  pw_t'(dn1.valid), pw_t'(0));

        // Mid-operation reset with a full skid
        dn1.ready = 1'b0;
        up1.valid = 1'b1; up1.data = pw_t'('h2A);
        cyc();
        up1.data = pw_t'('h2B);
        cyc();
        chk("mr_pre", pw_t'(occ1), pw_t'(2));
        up1.valid = 1'b0; dn1.ready = 1'b1; reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mr_vld",  pw_t'(dn1.valid), pw_t'(0));
        chk("mr_data", dn1.data,         pw_t'(0));
        chk("mr_occ",  pw_t'(occ1),      pw_t'(0));
        chk("mr_rdy",  pw_t'(up1.ready), pw_t'(1));
        cyc();
        chk("mr_nod",  pw_t'(dn1.valid), pw_t'(0));

        // SKID=0: combinational in_ready under stall
        idle();
        up0.valid = 1'b1; up0.data = pw_t'('h4);
        cyc();
        chk("s0_vld",  pw_t'(dn0.valid), pw_t'(1));
        chk("s0_d4",   dn0.data,         pw_t'('h4));
        up0.data = pw_t'('h5);
        #1;
        chk("s0_rdy0", pw_t'(up0.ready), pw_t'(0));
        dn0.ready = 1'b1;
        #1;
        chk("s0_rdy1", pw_t'(up0.ready), pw_t'(1));
        cyc();
        chk("s0_d5",   dn0.data,    pw_t'('h5));
        chk("s0_occ",  pw_t'(occ0), pw_t'(1));
        up0.valid = 1'b0;
        cyc();
        chk("s0_empty", pw_t'(dn0.valid), pw_t'(0));

        // Random traffic against an ordered scoreboard, both builds at once
        idle();
        q1.delete(); q0.delete();
        acc1 = 1'b0; acc0 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!(up1.valid && !acc1)) begin
                up1.valid = 1'($urandom_range(0, 1));
                up1.data  = pw_t'($urandom);
            end
            if (!(up0.valid && !acc0)) begin
                up0.valid = 1'($urandom_range(0, 1));
                up0.data  = pw_t'($urandom);
            end
            dn1.ready = ($urandom_range(0, 3) != 0);
            dn0.ready = ($urandom_range(0, 3) != 0);
            flush1    = ($urandom_range(0, 15) == 0);
            flush0    = ($urandom_range(0, 15) == 0);
            #1;
            er1 = (q1.size() < 2);
            er0 = (q0.size() == 0) || dn0.ready;
            chk("r1_rdy",  pw_t'(up1.ready), pw_t'(er1));
            chk("r1_vld",  pw_t'(dn1.valid), pw_t'(q1.size() != 0));
            chk("r1_data", dn1.data,         (q1.size() != 0) ? q1[0] : pw_t'(0));
            chk("r1_occ",  pw_t'(occ1),      pw_t'(q1.size()));
            chk("r0_rdy",  pw_t'(up0.ready), pw_t'(er0));
            chk("r0_vld",  pw_t'(dn0.valid), pw_t'(q0.size() != 0));
            chk("r0_data", dn0.data,         (q0.size() != 0) ? q0[0] : pw_t'(0));
            chk("r0_occ",  pw_t'(occ0),      pw_t'(q0.size()));
            acc1 = up1.valid && er1;
            acc0 = up0.valid && er0;
            pop1 = (q1.size() != 0) && dn1.ready;
            pop0 = (q0.size() != 0) && dn0.ready;
            if (pop1) void'(q1.pop_front());
            if (pop0) void'(q0.pop_front());
            if (flush1) q1.delete();
            else if (acc1) q1.push_back(up1.data);
            if (flush0) q0.delete();
            else if (acc0) q0.push_back(up0.data);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
